control_banco_registros: RTL
============================

# control_banco_registros

Write-port controller for the 32×32 register file (`banco_registros`). After reset it clears x1..x31 by sequencing zero writes. It then shares the single write port between the core writeback stage and a debug requester, using fixed priority with starvation relief. All register-file write signals it drives are registered; writes to x0 are absorbed here and never reach the register file.

## Interface
- `DATA_W`, 32, register data width.
- `ADDR_W`, 5, register index width (32 registers).
- `STARVE_MAX`, 4, consecutive stalled cycles of a pending debug request before debug is forced a grant (range 1..15).
- `CLK`  in  1  clock, all state updates on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `wb_valid`  in  1  core writeback request.
- `wb_ready`  out  1  core request accepted this cycle (when `wb_valid` is also high).
- `wb_reg`  in  ADDR_W  core destination register.
- `wb_data`  in  DATA_W  core write data.
- `dbg_valid`  in  1  debug write request.
- `dbg_ready`  out  1  debug request accepted this cycle (when `dbg_valid` is also high).
- `dbg_reg`  in  ADDR_W  debug destination register.
- `dbg_data`  in  DATA_W  debug write data.
- `writeReg`  out  ADDR_W  to register file, registered.
- `writeData`  out  DATA_W  to register file, registered.
- `RegWrite`  out  1  to register file, registered write enable.
- `busy`  out  1  high while the clear sequence is running.

## Operation
- States: INIT and RUN. Reset enters INIT with `init_cnt`=1.
- INIT:
  - Each cycle, register `RegWrite`=1, `writeReg`=`init_cnt`, `writeData`=0, then increment `init_cnt`.
  - When `init_cnt`=31, that write is issued and the next state is RUN.
  - `wb_ready`=`dbg_ready`=0. `busy`=1.
- RUN, ready generation (combinational, from state and registered `force`):
  - `wb_ready` = !`force`.
  - `dbg_ready` = `force` | !`wb_valid`.
- RUN, accept rule:
  - A handshake (valid & ready) captures reg/data into the output registers at that edge.
  - `RegWrite` is set to (reg != 0).
  - At most one handshake occurs per cycle.
- No handshake: `RegWrite` is registered 0, and `writeReg`/`writeData` hold their last values.
- Writes to x0: the request is accepted (ready honoured), but `RegWrite`=0, so the register file never sees it.
- Starvation counter `starve_cnt` (4 bits):
  - Increments each RUN cycle with `dbg_valid` & !`dbg_ready`.
  - Clears on a debug handshake or when `dbg_valid`=0.
  - When `starve_cnt` reaches STARVE_MAX, `force` is registered 1 for exactly one cycle.
  - `force` clears after that cycle regardless of outcome.
- Simultaneous requests without `force`: core wins and debug waits.
- Simultaneous requests with `force`: debug wins, and `wb_ready`=0 that cycle.
- Requesters must hold reg/data stable while valid is high and ready is low.
- `busy`=(state==INIT).

## Timing
- Reset values (asynchronous, while `RST_N`=0):
  - Output registers: `RegWrite`=0, `writeReg`=0, `writeData`=0.
  - Internal: state=INIT, `init_cnt`=1, `starve_cnt`=0, `force`=0.
  - Derived outputs: `busy`=1, `wb_ready`=0, `dbg_ready`=0.
- Reset release: the first rising edge registers the write to x1.
  - Cycles 1..31 after release show `RegWrite`=1 with `writeReg`=1..31.
  - `busy` falls in the cycle that shows `writeReg`=31.
  - The first handshake is possible in that same cycle.
- Write latency: a handshake at edge N gives `RegWrite`/`writeReg`/`writeData` valid during cycle N..N+1, and the register file writes at edge N+1.
  - A read of that register returns the new data after edge N+1.
- Throughput: one write per cycle. Back-to-back handshakes produce back-to-back `RegWrite` pulses.
- Forced-grant timing: a debug request stalled from cycle 0 sees `starve_cnt`=STARVE_MAX after STARVE_MAX stalled cycles, and is granted in the next cycle.
- Reset mid-operation (INIT or RUN): all outputs return to their reset values immediately, and any in-flight registered write is dropped.
  - The clear sequence restarts at x1.

## Test plan
- Reset release: observe 31 consecutive cycles with `RegWrite`=1, `writeReg`=1..31, `writeData`=0. `busy` falls in the `writeReg`=31 cycle, and both readies are 0 before it.
- Core write: x13=0x0000A234 (`wb_valid` one cycle in RUN) -> `wb_ready`=1, then the next cycle shows `RegWrite`=1, `writeReg`=13, `writeData`=0x0000A234. A register-file read of x13 one edge later gives 0x0000A234.
- x0 write: core writes x0=0x000000A1 -> `wb_ready`=1 and `RegWrite` stays 0. A read of x0 returns 0.
- Back-to-back core writes: x16=0x1234, then x24=0x2345 on consecutive cycles -> two consecutive `RegWrite` pulses. Simultaneous reads on ports 1/2 return 0x1234 and 0x2345.
- Arbitration: `wb_valid` is held high continuously, plus debug writes x5=0xDEAD with STARVE_MAX=4.
  - Core is granted for 4 cycles.
  - Debug is granted in the 5th cycle with `wb_ready`=0.
  - Core resumes the following cycle.
- Reset mid-INIT: `RST_N` driven low while `writeReg`=10 -> `RegWrite`=0 and `busy`=1 immediately. After release, the clear sequence restarts at `writeReg`=1.

Source files
------------

// File: rtl/control_banco_registros.sv
// Write-port controller for the 32x32 register file: clears x1..x31 after reset,
// then arbitrates the single write port between core writeback and debug.
module control_banco_registros #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_reg,
    input  logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              RegWrite,
    output logic              busy
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_REG   = {ADDR_W{1'b1}};
    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   init_cnt_reg, init_cnt_next;
    logic [3:0]          starve_cnt_reg, starve_cnt_next;
    logic                force_reg, force_next;
    logic                reg_write_next;
    logic [ADDR_W-1:0]   write_reg_next;
    logic [DATA_W-1:0]   write_data_next;
    logic                wb_hs, dbg_hs;

    // Readies depend only on state, the registered force flag and wb_valid,
    // so the two handshakes are mutually exclusive by construction.
    always_comb begin
        busy      = (state_reg == INIT);
        wb_ready  = (state_reg == RUN) && !force_reg;
        dbg_ready = (state_reg == RUN) && (force_reg || !wb_valid);
        wb_hs     = wb_valid && wb_ready;
        dbg_hs    = dbg_valid && dbg_ready;
    end

    always_comb begin
        state_next      = state_reg;
        init_cnt_next   = init_cnt_reg;
        starve_cnt_next = starve_cnt_reg;
        force_next      = 1'b0;
        reg_write_next  = 1'b0;
        write_reg_next  = writeReg;
        write_data_next = writeData;

        if (state_reg == INIT) begin
            reg_write_next  = 1'b1;
            write_reg_next  = init_cnt_reg;
            write_data_next = '0;
            init_cnt_next   = init_cnt_reg + ADDR_W'(1);
            if (init_cnt_reg == LAST_REG) begin
                state_next = RUN;
            end
        end else begin
            if (wb_hs) begin
                reg_write_next  = (wb_reg != '0);
                write_reg_next  = wb_reg;
                write_data_next = wb_data;
            end else if (dbg_hs) begin
                reg_write_next  = (dbg_reg != '0);
                write_reg_next  = dbg_reg;
                write_data_next = dbg_data;
            end

            // Force is raised on the same edge the counter reaches the limit,
            // so the stalled request is granted in the very next cycle.
            if (dbg_valid && !dbg_ready) begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
                force_next      = ((starve_cnt_reg + 4'd1) == STARVE_LIM);
            end else begin
                starve_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= INIT;
            init_cnt_reg   <= ADDR_W'(1);
            starve_cnt_reg <= '0;
            force_reg      <= 1'b0;
            RegWrite       <= 1'b0;
            writeReg       <= '0;
            writeData      <= '0;
        end else begin
            state_reg      <= state_next;
            init_cnt_reg   <= init_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            force_reg      <= force_next;
            RegWrite       <= reg_write_next;
            writeReg       <= write_reg_next;
            writeData      <= write_data_next;
        end
    end

endmodule
